// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider bank.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ALIGN,
    SETTLE,
    LOCKED
  } state_e;

  // A phase at or beyond the ratio has no valid counter position; start from zero instead.
  function automatic int unsigned clamp_phase(int unsigned phase, int unsigned div);
    return (phase >= div) ? 0 : phase;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: modulo-D counter with registered enable pulse and square wave.
module clk_div_chan #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] start_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             en_o,
  output logic             div_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half;
  logic             en_d, div_d;

  always_comb begin
    half  = (div_i >> 1) + DIV_W'(div_i[0]);
    cnt_d = cnt_q + ONE;
    if (load_i) begin
      cnt_d = start_i;
    end else if (div_i == '0 || cnt_q >= div_i - ONE) begin
      cnt_d = '0;
    end
    en_d  = (div_i != '0) && (cnt_q == div_i - ONE);
    div_d = (div_i != '0) && (cnt_q < half);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      en_o  <= 1'b0;
      div_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_o  <= en_d;
      div_o <= div_d;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CLK runtime-programmable integer dividers with shadow config and PLL-style lock.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned               N_CLK       = 3,
  parameter int unsigned               DIV_W       = 16,
  parameter int unsigned               LOCK_CYCLES = 16,
  parameter logic [N_CLK*DIV_W-1:0]    DEFAULT_DIV = {16'd100, 16'd4, 16'd1},
  localparam int unsigned              CH_W        = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             sync_req,
  output logic [N_CLK-1:0] en_o,
  output logic [N_CLK-1:0] div_o,
  output logic             locked
);

  localparam int unsigned SW = $clog2(LOCK_CYCLES + 1);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] phase;
  } chan_cfg_t;

  state_e           state_q;
  logic [SW-1:0]    settle_q;
  logic             locked_q;
  chan_cfg_t        shadow_q  [N_CLK];
  logic [DIV_W-1:0] act_div_q [N_CLK];
  logic             cfg_fire;
  logic             load;
  logic [N_CLK-1:0] en_raw, div_raw;

  assign cfg_ready = (state_q != ALIGN);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign load      = (state_q == ALIGN);

  // Out-of-range channel numbers match no entry, so the handshake completes and the write is dropped.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CLK; i++) begin
        shadow_q[i] <= '{div: DEFAULT_DIV[i*DIV_W +: DIV_W], phase: '0};
      end
    end else begin
      for (int unsigned i = 0; i < N_CLK; i++) begin
        if (cfg_fire && 32'(cfg_chan) == i) begin
          shadow_q[i] <= '{div: cfg_div, phase: cfg_phase};
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALIGN;
      settle_q <= '0;
      locked_q <= 1'b0;
      for (int unsigned i = 0; i < N_CLK; i++) begin
        act_div_q[i] <= DEFAULT_DIV[i*DIV_W +: DIV_W];
      end
    end else begin
      case (state_q)
        ALIGN: begin
          for (int unsigned i = 0; i < N_CLK; i++) begin
            act_div_q[i] <= shadow_q[i].div;
          end
          settle_q <= '0;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == SW'(LOCK_CYCLES - 1)) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        default: ;
      endcase
      // Realign overrides whatever the current state decided.
      if (sync_req) begin
        state_q  <= ALIGN;
        locked_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CLK; i++) begin : g_chan
    logic [DIV_W-1:0] start;
    assign start = DIV_W'(clamp_phase(32'(shadow_q[i].phase), 32'(shadow_q[i].div)));

    clk_div_chan #(.DIV_W(DIV_W)) u_chan (
      .clk_i   (refclk),
      .rst_ni  (rst_n),
      .load_i  (load),
      .start_i (start),
      .div_i   (act_div_q[i]),
      .en_o    (en_raw[i]),
      .div_o   (div_raw[i])
    );
  end

  assign en_o   = en_raw  & {N_CLK{locked_q}};
  assign div_o  = div_raw & {N_CLK{locked_q}};
  assign locked = locked_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised self-checking bench for clk_div_bank against an arithmetic phase model.
module tb_clk_div_bank;

  localparam int unsigned N    = 3;
  localparam int unsigned LOCK = 16;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [15:0] cfg_div;
  logic [15:0] cfg_phase;
  logic        sync_req;
  logic [2:0]  en_o;
  logic [2:0]  div_o;
  logic        locked;

  clk_div_bank #(
    .N_CLK       (3),
    .DIV_W       (16),
    .LOCK_CYCLES (16),
    .DEFAULT_DIV ({16'd100, 16'd4, 16'd1})
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .sync_req  (sync_req),
    .en_o      (en_o),
    .div_o     (div_o),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int unsigned edge_cnt = 0;
  always @(posedge refclk) edge_cnt <= edge_cnt + 1;

  // Reference model: configuration tables plus the edge index at which ALIGN takes effect.
  int unsigned sh_div [N];
  int unsigned sh_ph  [N];
  int unsigned act_div[N];
  int unsigned act_ph [N];
  int          align_edge;
  bit          in_reset;
  int unsigned passed = 0;
  int unsigned total  = 0;

  function automatic void load_defaults();
    sh_div[0] = 1; sh_div[1] = 4; sh_div[2] = 100;
    for (int i = 0; i < N; i++) sh_ph[i] = 0;
  endfunction

  function automatic void apply_shadow();
    for (int i = 0; i < N; i++) begin
      act_div[i] = sh_div[i];
      act_ph[i]  = (sh_ph[i] >= sh_div[i]) ? 0 : sh_ph[i];
    end
  endfunction

  // {locked, cfg_ready, en[2:0], div[2:0]} expected for the current cycle.
  function automatic logic [7:0] model_out();
    logic [7:0]  r;
    int          n;
    int unsigned x;
    r = '0;
    if (in_reset) return r;
    n = int'(edge_cnt) - align_edge;
    r[6] = (n >= 0);
    if (n >= int'(LOCK)) begin
      r[7] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (act_div[i] != 0) begin
          x = (act_ph[i] + unsigned'(n) - 1) % act_div[i];
          r[3+i] = (x == act_div[i] - 1);
          r[i]   = (x < (act_div[i] + 1) / 2);
        end
      end
    end
    return r;
  endfunction

  // One input cycle starting and ending on a falling edge; updates the model at the rising edge.
  task automatic drive_cycle(input bit v, input int unsigned ch, input int unsigned d,
                             input int unsigned p, input bit s);
    bit acc;
    cfg_valid = v; cfg_chan = 2'(ch); cfg_div = 16'(d); cfg_phase = 16'(p); sync_req = s;
    @(posedge refclk);
    #1;
    acc = !in_reset && (int'(edge_cnt) - 1 >= align_edge);
    if (v && acc && ch < N) begin
      sh_div[ch] = d & 16'hFFFF;
      sh_ph[ch]  = p & 16'hFFFF;
    end
    if (s) begin
      apply_shadow();
      align_edge = int'(edge_cnt) + 1;
    end
    @(negedge refclk);
    cfg_valid = 1'b0; sync_req = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    load_defaults();
    apply_shadow();
    align_edge = int'(edge_cnt) + 1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    for (int c = 0; c < 3; c++) begin
      @(negedge refclk);
      obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== 8'h00) $display("FAIL reset_state cyc=%0d got=%b exp=%b", c, obs, 8'h00);
      else passed++;
    end
    release_reset();
    for (int c = 0; c < 250; c++) begin
      logic [7:0] ex;
      ex = model_out();
      obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL reset_release cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_ch1_reconfig();
    logic [7:0] obs, ex;
    drive_cycle(1, 1, 5, 2, 0);
    drive_cycle(0, 0, 0, 0, 1);
    for (int c = 0; c < 60; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL ch1_d5_p2 cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_shadow_only();
    logic [7:0] obs, ex;
    drive_cycle(1, 0, 6, 0, 0);
    for (int c = 0; c < 1000; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL shadow_no_sync cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_write_with_sync();
    logic [7:0] obs, ex;
    drive_cycle(1, 2, 10, 0, 1);
    for (int c = 0; c < 60; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL write_with_sync cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_disable_clamp();
    logic [7:0] obs, ex;
    drive_cycle(1, 1, 0, 0, 0);
    drive_cycle(1, 2, 3, 7, 1);
    for (int c = 0; c < 40; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL disable_clamp cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_restart_and_reset();
    logic [7:0] obs, ex;
    drive_cycle(0, 0, 0, 0, 1);
    for (int c = 0; c < 6; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL settle_restart_a cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
    drive_cycle(0, 0, 0, 0, 1);
    for (int c = 0; c < 30; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL settle_restart_b cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
    #1 rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    obs = {locked, cfg_ready, en_o, div_o};
    total++;
    if (obs !== 8'h00) $display("FAIL async_reset got=%b exp=%b", obs, 8'h00);
    else passed++;
    release_reset();
    for (int c = 0; c < 120; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL reset_defaults cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_max_ratio_held_sync();
    logic [7:0] obs, ex;
    drive_cycle(1, 0, 16'hFFFF, 16'hFFF0, 1);
    drive_cycle(1, 1, 2, 1, 1);
    drive_cycle(0, 0, 0, 0, 1);
    for (int c = 0; c < 60; c++) begin
      ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
      total++;
      if (obs !== ex) $display("FAIL max_ratio cyc=%0d got=%b exp=%b", c, obs, ex);
      else passed++;
      @(negedge refclk);
    end
  endtask

  task automatic test_random();
    logic [7:0] obs, ex;
    for (int it = 0; it < 10; it++) begin
      int unsigned nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < int'(nw); w++) begin
        drive_cycle(1, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 15),
                    (w == int'(nw) - 1) ? 1'b1 : 1'b0);
      end
      for (int c = 0; c < 50; c++) begin
        ex = model_out(); obs = {locked, cfg_ready, en_o, div_o};
        total++;
        if (obs !== ex) $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, c, obs, ex);
        else passed++;
        @(negedge refclk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_reset = 1'b1; align_edge = 0;
    cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_phase = '0; sync_req = 1'b0;
    load_defaults();
    apply_shadow();
    test_reset();
    test_ch1_reconfig();
    test_shadow_only();
    test_write_with_sync();
    test_disable_clamp();
    test_restart_and_reset();
    test_max_ratio_held_sync();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
